// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial data path
package serial_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // One-hot so the encoding lines up with the read/transfer controller
  typedef enum logic [3:0] {
    TX_IDLE   = 4'b0001,
    TX_LOADED = 4'b0010,
    TX_SHIFT  = 4'b0100,
    TX_DONE   = 4'b1000
  } tx_state_t;

endpackage

// File: rtl/serial_tx_shifter_if.sv
// rtl/serial_tx_shifter_if.sv - controller-to-serializer handshake bundle
interface serial_tx_shifter_if import serial_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  sample_data;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  tx_data;
  logic                  sout;
  logic                  sout_valid;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output sample_data, data_in, tx_data,
    input  sout, sout_valid, tx_busy, tx_done
  );

  modport slave (
    input  sample_data, data_in, tx_data,
    output sout, sout_valid, tx_busy, tx_done
  );

endinterface

// File: rtl/bit_period_counter.sv
// rtl/bit_period_counter.sv - counts clk cycles per serial bit, ticks at terminal count
module bit_period_counter #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx_shifter.sv
// rtl/serial_tx_shifter.sv - captures a parallel word and shifts it out serially with a done pulse
module serial_tx_shifter import serial_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BIT_CYCLES = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                clk,
  input  logic                reset,
  serial_tx_shifter_if.slave  bus
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] hold;
  logic                  loaded;
  logic [BW-1:0]         bit_cnt;
  logic                  sout_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  period_tick;

  assign bus.sout       = sout_r;
  assign bus.sout_valid = valid_r;
  assign bus.tx_busy    = busy_r;
  assign bus.tx_done    = done_r;

  function automatic logic [BW-1:0] bit_sel(input logic [BW-1:0] cnt);
    if (LSB_FIRST != 0) return cnt;
    else                return LAST - cnt;
  endfunction

  bit_period_counter #(.BIT_CYCLES(BIT_CYCLES)) u_period (
    .clk   (clk),
    .reset (reset),
    .clear (state != TX_SHIFT),
    .en    (state == TX_SHIFT),
    .tick  (period_tick)
  );

  // Outputs are registered from the next state, so they line up with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      hold    <= '0;
      loaded  <= 1'b0;
      bit_cnt <= '0;
      sout_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (bus.sample_data) begin
            hold   <= bus.data_in;
            loaded <= 1'b1;
            state  <= TX_LOADED;
          end
        end
        TX_LOADED: begin
          if (bus.sample_data) begin
            hold <= bus.data_in;
          end else if (bus.tx_data && loaded) begin
            state   <= TX_SHIFT;
            bit_cnt <= '0;
            sout_r  <= hold[bit_sel('0)];
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        TX_SHIFT: begin
          if (period_tick) begin
            if (bit_cnt == LAST) begin
              state   <= TX_DONE;
              sout_r  <= 1'b0;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
              loaded  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sout_r  <= hold[bit_sel(bit_cnt + 1'b1)];
            end
          end
        end
        TX_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= TX_IDLE;
        end
        default: begin
          state   <= TX_IDLE;
          sout_r  <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
- Output-side serializer driven by the memory read/transfer controller: captures a parallel word on `sample_data`, shifts it out one bit at a time on `tx_data`, and returns a one-cycle `tx_done` pulse.
- Sits between the memory data bus / input buffer and the serial output pins.
- `tx_done` from this block is the completion input the controller waits on in its transmit states.

Parameters:
- DATA_WIDTH, 8, width of the parallel word and number of serial bits per transfer (min 2).
- BIT_CYCLES, 1, clk cycles each bit is held on `sout` (min 1).
- LSB_FIRST, 1, 1: bit 0 is sent first; 0: bit DATA_WIDTH-1 is sent first.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- sample_data  in  1  level; while high in IDLE/LOADED, data_in is captured each cycle.
- data_in  in  DATA_WIDTH  parallel word from memory or input buffer.
- tx_data  in  1  level start request; controller holds it high until tx_done.
- sout  out  1  serial data bit.
- sout_valid  out  1  high while sout carries a payload bit.
- tx_busy  out  1  high in SHIFT and DONE.
- tx_done  out  1  one-cycle pulse after the last bit period.

Behaviour:
- Reset values: sout=0, sout_valid=0, tx_busy=0, tx_done=0, hold register=0, loaded flag=0, bit/cycle counters=0, state=IDLE.
- Reset mid-transfer aborts immediately; no tx_done is produced.
- All outputs are registered.
- States and transitions:
  - IDLE: sample_data=1 -> capture data_in, set loaded, go to LOADED. tx_data alone is ignored (no word to send).
  - LOADED: sample_data=1 -> recapture (last sample wins). tx_data=1 with sample_data=0 -> go to SHIFT; bit counter=0, cycle counter=0. If both are high, the capture wins and SHIFT starts next cycle if tx_data is still high.
  - SHIFT: sout = hold[bit_idx], where bit_idx = bit counter if LSB_FIRST, else DATA_WIDTH-1-bit counter. sout_valid=1.
    - The cycle counter counts 0..BIT_CYCLES-1; at terminal count the bit counter increments.
    - After bit DATA_WIDTH-1 completes its period, go to DONE.
    - sample_data and data_in are ignored; the hold register is frozen.
  - DONE: exactly one cycle. tx_done=1, sout_valid=0, sout=0, loaded cleared. Go to IDLE.
- Latency: first bit appears on sout the cycle after SHIFT is entered. A transfer occupies DATA_WIDTH*BIT_CYCLES cycles of sout_valid=1, followed by one tx_done cycle.
- tx_data still high after DONE does not retrigger; a new sample_data is required.
- tx_data dropping during SHIFT has no effect; the transfer completes.
- Counter widths: $clog2(DATA_WIDTH) bits for the bit counter and $clog2(BIT_CYCLES)+1 bits for the cycle counter. Both wrap only through explicit clear, never by overflow.

Decomposition:
- Shared package serial_pkg holds:
  - state enum TX_IDLE/TX_LOADED/TX_SHIFT/TX_DONE, one-hot encoded, matching the controller's one-hot convention;
  - the default DATA_WIDTH constant, shared with the controller and the deserializer.
- One sub-module: bit_period_counter (parameter BIT_CYCLES; inputs clk, reset, clear, en; output tick at terminal count). It is reused by the receive side.

Test Plan:
- Reset, then sample_data=1 with data_in=8'hA5 for 1 cycle, then tx_data=1: sout sequence is 1,0,1,0,0,1,0,1 (LSB first) over 8 cycles with sout_valid=1. tx_done pulses once on cycle 9. tx_busy is high for cycles 1-9.
- LSB_FIRST=0, BIT_CYCLES=3, data_in=8'hC3: each bit is held 3 cycles, MSB first (1,1,0,0,0,0,1,1). sout_valid is high for 24 cycles, then a single tx_done.
- tx_data=1 without a prior sample: state stays IDLE, sout_valid=0, tx_done never asserts. Then sample 8'h01 with tx_data still high: capture occurs and SHIFT starts the following cycle.
- During SHIFT, drive sample_data=1 with data_in=8'hFF and drop tx_data: the serialized word is still the original 8'h3C, and tx_done arrives on schedule. Keeping tx_data high after tx_done starts no second transfer.
- Assert reset asynchronously at bit 4 of a transfer: all outputs go to 0 in the same cycle with no tx_done. After release the block is in IDLE with loaded=0.
- Back-to-back transfers: sample 8'h55, transmit, then in the cycle after tx_done sample 8'hAA and transmit. Expect two clean 8-bit frames, each followed by exactly one tx_done.
